// File: rtl/matrix_pkg.sv
// Shared constants, state encoding and request range check for the matrix-store read arbiter.
package matrix_pkg;

  localparam int unsigned MAT_W       = 200;
  localparam int unsigned DIM_W       = 3;
  localparam int unsigned IDX_W       = 2;
  localparam int unsigned MAX_DIM     = 5;
  localparam int unsigned MAX_IDX     = 1;
  localparam int unsigned NUM_CLI_DEF = 3;
  // Width of a client index; covers up to four clients.
  localparam int unsigned CLI_W       = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

  // True when a request addresses a real matrix: dims 1..MAX_DIM, slot 0..MAX_IDX.
  function automatic logic req_in_range(input logic [DIM_W-1:0] row,
                                        input logic [DIM_W-1:0] col,
                                        input logic [IDX_W-1:0] idx);
    return (row != '0) && (row <= DIM_W'(MAX_DIM)) &&
           (col != '0) && (col <= DIM_W'(MAX_DIM)) &&
           (idx <= IDX_W'(MAX_IDX));
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Round-robin priority pick: first requester found searching upward from last_grant+1.
module rr_pick3
  import matrix_pkg::*;
#(
  parameter int unsigned NUM_CLI = NUM_CLI_DEF
) (
  input  logic [NUM_CLI-1:0] i_req,
  input  logic [CLI_W-1:0]   i_last,
  output logic [NUM_CLI-1:0] o_onehot,
  output logic [CLI_W-1:0]   o_idx,
  output logic               o_valid
);

  logic [CLI_W-1:0] w_cand;

  // Walk the clients in rotation order and stop at the first active request.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    w_cand   = '0;
    for (int unsigned k = 1; k <= NUM_CLI; k++) begin
      w_cand = CLI_W'((32'(i_last) + k) % NUM_CLI);
      if (!o_valid && i_req[w_cand]) begin
        o_valid          = 1'b1;
        o_onehot[w_cand] = 1'b1;
        o_idx            = w_cand;
      end
    end
  end

endmodule

// File: rtl/matrix_rd_arbiter.sv
// Shares one matrix-store read port among NUM_CLI requesters with round-robin arbitration,
// request range pre-check and a response timeout. All outputs come straight from registers.
module matrix_rd_arbiter
  import matrix_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned NUM_CLI     = NUM_CLI_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_CLI-1:0]       i_cli_req,
  input  logic [NUM_CLI*DIM_W-1:0] i_cli_row,
  input  logic [NUM_CLI*DIM_W-1:0] i_cli_col,
  input  logic [NUM_CLI*IDX_W-1:0] i_cli_idx,
  output logic [NUM_CLI-1:0]       o_cli_grant,
  output logic [NUM_CLI-1:0]       o_cli_ready,
  output logic [NUM_CLI-1:0]       o_cli_err,
  output logic [MAT_W-1:0]         o_cli_data,
  output logic [DIM_W-1:0]         o_cli_dim_m,
  output logic [DIM_W-1:0]         o_cli_dim_n,
  output logic                     o_busy,
  output logic                     o_read_en,
  output logic [DIM_W-1:0]         o_rd_row,
  output logic [DIM_W-1:0]         o_rd_col,
  output logic [IDX_W-1:0]         o_rd_mat_index,
  input  logic [MAT_W-1:0]         i_rd_data_flow,
  input  logic                     i_rd_ready,
  input  logic                     i_err_rd
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  arb_state_e         r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [CLI_W-1:0]   r_last, w_last_nxt;
  logic [NUM_CLI-1:0] r_grant, w_grant_nxt;
  logic [NUM_CLI-1:0] r_ready, w_ready_nxt;
  logic [NUM_CLI-1:0] r_err, w_err_nxt;
  logic               r_read_en, w_read_en_nxt;
  logic               r_busy, w_busy_nxt;
  logic [DIM_W-1:0]   r_row, w_row_nxt;
  logic [DIM_W-1:0]   r_col, w_col_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [DIM_W-1:0]   r_dim_m, w_dim_m_nxt;
  logic [DIM_W-1:0]   r_dim_n, w_dim_n_nxt;
  logic [MAT_W-1:0]   r_data, w_data_nxt;

  logic [NUM_CLI-1:0] w_win_onehot;
  logic [CLI_W-1:0]   w_win_idx;
  logic               w_win_any;
  logic [DIM_W-1:0]   w_win_row;
  logic [DIM_W-1:0]   w_win_col;
  logic [IDX_W-1:0]   w_win_slot;

  rr_pick3 #(
    .NUM_CLI (NUM_CLI)
  ) u_pick (
    .i_req    (i_cli_req),
    .i_last   (r_last),
    .o_onehot (w_win_onehot),
    .o_idx    (w_win_idx),
    .o_valid  (w_win_any)
  );

  assign w_win_row  = i_cli_row[32'(w_win_idx) * DIM_W +: DIM_W];
  assign w_win_col  = i_cli_col[32'(w_win_idx) * DIM_W +: DIM_W];
  assign w_win_slot = i_cli_idx[32'(w_win_idx) * IDX_W +: IDX_W];

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_last_nxt    = r_last;
    w_grant_nxt   = r_grant;
    w_ready_nxt   = '0;
    w_err_nxt     = '0;
    w_read_en_nxt = 1'b0;
    w_row_nxt     = r_row;
    w_col_nxt     = r_col;
    w_idx_nxt     = r_idx;
    w_dim_m_nxt   = r_dim_m;
    w_dim_n_nxt   = r_dim_n;
    w_data_nxt    = r_data;
    unique case (r_state)
      StIdle: begin
        if (w_win_any) begin
          w_grant_nxt = w_win_onehot;
          w_last_nxt  = w_win_idx;
          w_row_nxt   = w_win_row;
          w_col_nxt   = w_win_col;
          w_idx_nxt   = w_win_slot;
          if (req_in_range(w_win_row, w_win_col, w_win_slot)) begin
            w_state_nxt   = StIssue;
            w_read_en_nxt = 1'b1;
          end else begin
            // Out-of-range request never reaches the store.
            w_state_nxt = StResp;
            w_err_nxt   = w_win_onehot;
          end
        end
      end
      StIssue: begin
        w_cnt_nxt   = '0;
        w_state_nxt = StWait;
      end
      StWait: begin
        if (i_err_rd) begin
          // Error outranks a coincident rd_ready; captured data is left alone.
          w_state_nxt = StResp;
          w_err_nxt   = r_grant;
        end else if (i_rd_ready) begin
          w_state_nxt = StResp;
          w_ready_nxt = r_grant;
          w_data_nxt  = i_rd_data_flow;
          w_dim_m_nxt = r_row;
          w_dim_n_nxt = r_col;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          w_state_nxt = StResp;
          w_err_nxt   = r_grant;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      StResp: begin
        w_grant_nxt = '0;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
    w_busy_nxt = (w_state_nxt != StIdle);
  end

  // State and registered outputs; reset leaves client 0 first in line.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_last    <= CLI_W'(NUM_CLI - 1);
      r_grant   <= '0;
      r_ready   <= '0;
      r_err     <= '0;
      r_read_en <= 1'b0;
      r_busy    <= 1'b0;
      r_row     <= '0;
      r_col     <= '0;
      r_idx     <= '0;
      r_dim_m   <= '0;
      r_dim_n   <= '0;
      r_data    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_last    <= w_last_nxt;
      r_grant   <= w_grant_nxt;
      r_ready   <= w_ready_nxt;
      r_err     <= w_err_nxt;
      r_read_en <= w_read_en_nxt;
      r_busy    <= w_busy_nxt;
      r_row     <= w_row_nxt;
      r_col     <= w_col_nxt;
      r_idx     <= w_idx_nxt;
      r_dim_m   <= w_dim_m_nxt;
      r_dim_n   <= w_dim_n_nxt;
      r_data    <= w_data_nxt;
    end
  end

  assign o_cli_grant    = r_grant;
  assign o_cli_ready    = r_ready;
  assign o_cli_err      = r_err;
  assign o_cli_data     = r_data;
  assign o_cli_dim_m    = r_dim_m;
  assign o_cli_dim_n    = r_dim_n;
  assign o_busy         = r_busy;
  assign o_read_en      = r_read_en;
  assign o_rd_row       = r_row;
  assign o_rd_col       = r_col;
  assign o_rd_mat_index = r_idx;

endmodule

// File: tb/tb_matrix_rd_arbiter.sv
// Self-checking bench for matrix_rd_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model (rotation pick, range rule, response outcome).
module tb_matrix_rd_arbiter;

  localparam int T = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   cli_req = '0;
  logic [8:0]   cli_row = '0;
  logic [8:0]   cli_col = '0;
  logic [5:0]   cli_idx = '0;
  logic [2:0]   cli_grant, cli_ready, cli_err;
  logic [199:0] cli_data;
  logic [2:0]   cli_dim_m, cli_dim_n;
  logic         busy, read_en;
  logic [2:0]   rd_row, rd_col;
  logic [1:0]   rd_mat_index;
  logic [199:0] rd_data_flow = '0;
  logic         rd_ready = 1'b0;
  logic         err_rd = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // Per-client request fields and the model's view of arbiter state.
  logic [2:0]   f_row [3];
  logic [2:0]   f_col [3];
  logic [1:0]   f_idx [3];
  int           m_last;
  logic [199:0] m_data;
  logic [2:0]   m_dim_m, m_dim_n;

  matrix_rd_arbiter #(
    .TIMEOUT_CYC (T),
    .NUM_CLI     (3)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_cli_req      (cli_req),
    .i_cli_row      (cli_row),
    .i_cli_col      (cli_col),
    .i_cli_idx      (cli_idx),
    .o_cli_grant    (cli_grant),
    .o_cli_ready    (cli_ready),
    .o_cli_err      (cli_err),
    .o_cli_data     (cli_data),
    .o_cli_dim_m    (cli_dim_m),
    .o_cli_dim_n    (cli_dim_n),
    .o_busy         (busy),
    .o_read_en      (read_en),
    .o_rd_row       (rd_row),
    .o_rd_col       (rd_col),
    .o_rd_mat_index (rd_mat_index),
    .i_rd_data_flow (rd_data_flow),
    .i_rd_ready     (rd_ready),
    .i_err_rd       (err_rd)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_fields();
    cli_row = {f_row[2], f_row[1], f_row[0]};
    cli_col = {f_col[2], f_col[1], f_col[0]};
    cli_idx = {f_idx[2], f_idx[1], f_idx[0]};
  endtask

  // Bounded wait for the read strobe; ok=0 if it never shows.
  task automatic wait_read_en(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (read_en === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [199:0] rand_mat();
    logic [223:0] t;
    for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom();
    return t[199:0];
  endfunction

  // Rotation order after the last winner: last+1, last+2, ... modulo 3.
  function automatic int pick(input logic [2:0] mask, input int last);
    int c;
    for (int k = 1; k <= 3; k++) begin
      c = (last + k) % 3;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit fields_ok(input int c);
    return (f_row[c] >= 1) && (f_row[c] <= 5) && (f_col[c] >= 1) && (f_col[c] <= 5) &&
           (f_idx[c] <= 1);
  endfunction

  function automatic bit outputs_zero();
    return ({cli_grant, cli_ready, cli_err, cli_dim_m, cli_dim_n, busy, read_en, rd_row, rd_col,
             rd_mat_index} === '0) && (cli_data === '0);
  endfunction

  task automatic model_reset();
    m_last  = 2;
    m_data  = '0;
    m_dim_m = '0;
    m_dim_n = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_checks++;
    if (!outputs_zero()) begin
      n_errors++;
      $display("FAIL reset_outputs: grant=%b ready=%b err=%b busy=%b read_en=%b row=%0d col=%0d want all 0",
               cli_grant, cli_ready, cli_err, busy, read_en, rd_row, rd_col);
    end
    rst_n = 1'b1;
    model_reset();
    repeat (2) step();
    n_checks++;
    if (busy !== 1'b0 || read_en !== 1'b0 || cli_grant !== 3'b000) begin
      n_errors++;
      $display("FAIL idle_no_req: busy=%b read_en=%b grant=%b want 0 0 000", busy, read_en,
               cli_grant);
    end
  endtask

  task automatic test_contention();
    int order [4] = '{0, 1, 2, 0};
    bit ok;
    logic [199:0] d;
    logic [2:0] oh;
    for (int c = 0; c < 3; c++) begin
      f_row[c] = 3'(c + 1);
      f_col[c] = 3'(5 - c);
      f_idx[c] = 2'(c % 2);
    end
    apply_fields();
    cli_req = 3'b111;
    for (int t = 0; t < 4; t++) begin
      oh = 3'(1 << order[t]);
      wait_read_en(ok);
      n_checks++;
      if (!ok) begin
        n_errors++;
        $display("FAIL contention_read_en[%0d]: no read_en within bound", t);
        break;
      end
      n_checks++;
      if (cli_grant !== oh || rd_row !== f_row[order[t]] || rd_col !== f_col[order[t]]) begin
        n_errors++;
        $display("FAIL contention_grant[%0d]: grant=%b row=%0d col=%0d want %b %0d %0d", t,
                 cli_grant, rd_row, rd_col, oh, f_row[order[t]], f_col[order[t]]);
      end
      step();
      d = rand_mat();
      rd_data_flow = d;
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      m_last = order[t];
      m_data = d;
      m_dim_m = f_row[order[t]];
      m_dim_n = f_col[order[t]];
      n_checks++;
      if (cli_ready !== oh || cli_err !== 3'b000 || cli_data !== m_data) begin
        n_errors++;
        $display("FAIL contention_ready[%0d]: ready=%b err=%b data_ok=%b want %b 000 1", t,
                 cli_ready, cli_err, cli_data === m_data, oh);
      end
    end
    cli_req = 3'b000;
    step();
  endtask

  task automatic test_single();
    logic [199:0] d;
    f_row[1] = 3'd2;
    f_col[1] = 3'd3;
    f_idx[1] = 2'd1;
    apply_fields();
    cli_req = 3'b010;
    step();
    n_checks++;
    if (cli_grant !== 3'b010 || read_en !== 1'b1 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL single_issue: grant=%b read_en=%b busy=%b want 010 1 1", cli_grant,
               read_en, busy);
    end
    n_checks++;
    if (rd_row !== 3'd2 || rd_col !== 3'd3 || rd_mat_index !== 2'd1) begin
      n_errors++;
      $display("FAIL single_addr: row=%0d col=%0d idx=%0d want 2 3 1", rd_row, rd_col,
               rd_mat_index);
    end
    step();
    n_checks++;
    if (read_en !== 1'b0 || cli_ready !== 3'b000 || rd_row !== 3'd2 || rd_col !== 3'd3) begin
      n_errors++;
      $display("FAIL single_wait: read_en=%b ready=%b row=%0d col=%0d want 0 000 2 3", read_en,
               cli_ready, rd_row, rd_col);
    end
    d = rand_mat();
    rd_data_flow = d;
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    cli_req = 3'b000;
    m_last = 1;
    m_data = d;
    m_dim_m = 3'd2;
    m_dim_n = 3'd3;
    n_checks++;
    if (cli_ready !== 3'b010 || cli_err !== 3'b000 || cli_data !== m_data ||
        cli_dim_m !== 3'd2 || cli_dim_n !== 3'd3) begin
      n_errors++;
      $display("FAIL single_ready: ready=%b err=%b dims=%0d,%0d data_ok=%b want 010 000 2,3 1",
               cli_ready, cli_err, cli_dim_m, cli_dim_n, cli_data === m_data);
    end
    step();
    n_checks++;
    if (cli_ready !== 3'b000 || cli_grant !== 3'b000 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL single_done: ready=%b grant=%b busy=%b want 000 000 0", cli_ready,
               cli_grant, busy);
    end
  endtask

  task automatic test_timeout();
    int k_hit = -1;
    f_row[0] = 3'd4;
    f_col[0] = 3'd1;
    f_idx[0] = 2'd0;
    apply_fields();
    cli_req = 3'b001;
    step();
    n_checks++;
    if (read_en !== 1'b1 || cli_grant !== 3'b001) begin
      n_errors++;
      $display("FAIL timeout_issue: read_en=%b grant=%b want 1 001", read_en, cli_grant);
    end
    for (int k = 1; k <= T + 4; k++) begin
      step();
      if ((cli_err | cli_ready) !== 3'b000) begin
        k_hit = k;
        break;
      end
    end
    m_last = 0;
    n_checks++;
    if (k_hit != T + 1 || cli_err !== 3'b001 || cli_ready !== 3'b000 || cli_data !== m_data) begin
      n_errors++;
      $display("FAIL timeout_err: edge=%0d err=%b ready=%b data_ok=%b want %0d 001 000 1", k_hit,
               cli_err, cli_ready, cli_data === m_data, T + 1);
    end
    cli_req = 3'b000;
    step();
    n_checks++;
    if (busy !== 1'b0 || cli_grant !== 3'b000 || cli_err !== 3'b000) begin
      n_errors++;
      $display("FAIL timeout_idle: busy=%b grant=%b err=%b want 0 000 000", busy, cli_grant,
               cli_err);
    end
  endtask

  task automatic test_invalid();
    f_row[2] = 3'd6;
    f_col[2] = 3'd1;
    f_idx[2] = 2'd0;
    apply_fields();
    cli_req = 3'b100;
    step();
    n_checks++;
    if (cli_grant !== 3'b100 || cli_err !== 3'b100 || read_en !== 1'b0 || cli_ready !== 3'b000)
    begin
      n_errors++;
      $display("FAIL invalid_err: grant=%b err=%b read_en=%b ready=%b want 100 100 0 000",
               cli_grant, cli_err, read_en, cli_ready);
    end
    cli_req = 3'b000;
    m_last = 2;
    step();
    n_checks++;
    if (cli_err !== 3'b000 || cli_grant !== 3'b000 || busy !== 1'b0 || read_en !== 1'b0) begin
      n_errors++;
      $display("FAIL invalid_done: err=%b grant=%b busy=%b read_en=%b want 000 000 0 0",
               cli_err, cli_grant, busy, read_en);
    end
  endtask

  task automatic test_err_and_ready();
    bit ok;
    int w;
    for (int c = 0; c < 2; c++) begin
      f_row[c] = 3'd5;
      f_col[c] = 3'd5;
      f_idx[c] = 2'd0;
    end
    apply_fields();
    cli_req = 3'b011;
    w = pick(3'b011, m_last);
    wait_read_en(ok);
    n_checks++;
    if (!ok || cli_grant !== 3'(1 << w)) begin
      n_errors++;
      $display("FAIL both_grant: ok=%b grant=%b want 1 %b", ok, cli_grant, 3'(1 << w));
    end
    step();
    rd_data_flow = rand_mat();
    rd_ready = 1'b1;
    err_rd = 1'b1;
    step();
    rd_ready = 1'b0;
    err_rd = 1'b0;
    cli_req = 3'b000;
    m_last = w;
    n_checks++;
    if (cli_err !== 3'(1 << w) || cli_ready !== 3'b000 || cli_data !== m_data) begin
      n_errors++;
      $display("FAIL both_err_wins: err=%b ready=%b data_ok=%b want %b 000 1", cli_err,
               cli_ready, cli_data === m_data, 3'(1 << w));
    end
    step();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int w;
    logic [199:0] d;
    for (int c = 0; c < 3; c++) begin
      f_row[c] = 3'd1;
      f_col[c] = 3'(c + 2);
      f_idx[c] = 2'd1;
    end
    apply_fields();
    cli_req = 3'b111;
    w = pick(3'b111, m_last);
    wait_read_en(ok);
    n_checks++;
    if (!ok || cli_grant !== 3'(1 << w)) begin
      n_errors++;
      $display("FAIL rstmid_pre_grant: ok=%b grant=%b want 1 %b", ok, cli_grant, 3'(1 << w));
    end
    step();
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (!outputs_zero()) begin
      n_errors++;
      $display("FAIL rstmid_async: grant=%b busy=%b read_en=%b data_zero=%b want all 0",
               cli_grant, busy, read_en, cli_data === '0);
    end
    step();
    rst_n = 1'b1;
    model_reset();
    wait_read_en(ok);
    n_checks++;
    if (!ok || cli_grant !== 3'b001) begin
      n_errors++;
      $display("FAIL rstmid_first_grant: ok=%b grant=%b want 1 001", ok, cli_grant);
    end
    step();
    d = rand_mat();
    rd_data_flow = d;
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    cli_req = 3'b000;
    m_last = 0;
    m_data = d;
    m_dim_m = f_row[0];
    m_dim_n = f_col[0];
    n_checks++;
    if (cli_ready !== 3'b001 || cli_data !== m_data) begin
      n_errors++;
      $display("FAIL rstmid_ready: ready=%b data_ok=%b want 001 1", cli_ready,
               cli_data === m_data);
    end
    step();
  endtask

  task automatic test_random();
    logic [2:0] pend = 3'b000;
    logic [2:0] newbits, oh, exp_ready, exp_err;
    int w, kind, d, exp_k, k_hit, r;
    logic [199:0] resp;
    for (int n = 0; n < 60; n++) begin
      newbits = 3'($urandom_range(0, 7)) & ~pend;
      if ((pend | newbits) == 3'b000) newbits = 3'(1 << $urandom_range(0, 2));
      for (int c = 0; c < 3; c++) begin
        if (newbits[c]) begin
          if ($urandom_range(0, 4) == 0) begin
            f_row[c] = 3'($urandom_range(0, 7));
            f_col[c] = 3'($urandom_range(0, 7));
            f_idx[c] = 2'($urandom_range(0, 3));
          end else begin
            f_row[c] = 3'($urandom_range(1, 5));
            f_col[c] = 3'($urandom_range(1, 5));
            f_idx[c] = 2'($urandom_range(0, 1));
          end
        end
      end
      pend |= newbits;
      apply_fields();
      cli_req = pend;
      w = pick(pend, m_last);
      oh = 3'(1 << w);
      r = $urandom_range(0, 9);
      kind = (r <= 5) ? 0 : (r <= 7) ? 1 : (r == 8) ? 2 : 3;
      d = $urandom_range(0, 3);
      step();
      m_last = w;
      n_checks++;
      if (cli_grant !== oh || busy !== 1'b1) begin
        n_errors++;
        $display("FAIL rand_grant[%0d]: grant=%b busy=%b want %b 1", n, cli_grant, busy, oh);
      end
      if (!fields_ok(w)) begin
        n_checks++;
        if (cli_err !== oh || cli_ready !== 3'b000 || read_en !== 1'b0) begin
          n_errors++;
          $display("FAIL rand_invalid[%0d]: err=%b ready=%b read_en=%b want %b 000 0", n,
                   cli_err, cli_ready, read_en, oh);
        end
      end else begin
        n_checks++;
        if (read_en !== 1'b1 || rd_row !== f_row[w] || rd_col !== f_col[w] ||
            rd_mat_index !== f_idx[w]) begin
          n_errors++;
          $display("FAIL rand_issue[%0d]: read_en=%b row=%0d col=%0d idx=%0d want 1 %0d %0d %0d",
                   n, read_en, rd_row, rd_col, rd_mat_index, f_row[w], f_col[w], f_idx[w]);
        end
        // Stray response while the read is being issued must be ignored.
        rd_ready = 1'($urandom_range(0, 1));
        err_rd = 1'($urandom_range(0, 1));
        rd_data_flow = rand_mat();
        exp_k = (kind == 3) ? T + 1 : d + 2;
        k_hit = -1;
        resp = rand_mat();
        for (int k = 1; k <= T + 4; k++) begin
          if (k >= 2) begin
            rd_ready = 1'b0;
            err_rd = 1'b0;
            if (kind < 3 && k == d + 2) begin
              rd_data_flow = resp;
              rd_ready = (kind == 0 || kind == 2);
              err_rd = (kind == 1 || kind == 2);
            end
          end
          step();
          if (k == 1) begin
            n_checks++;
            if (read_en !== 1'b0) begin
              n_errors++;
              $display("FAIL rand_read_en_pulse[%0d]: read_en=%b want 0", n, read_en);
            end
          end
          if ((cli_ready | cli_err) !== 3'b000) begin
            k_hit = k;
            break;
          end
        end
        if (kind == 0) begin
          exp_ready = oh;
          exp_err = 3'b000;
          m_data = resp;
          m_dim_m = f_row[w];
          m_dim_n = f_col[w];
        end else begin
          exp_ready = 3'b000;
          exp_err = oh;
        end
        n_checks++;
        if (k_hit != exp_k || cli_ready !== exp_ready || cli_err !== exp_err) begin
          n_errors++;
          $display("FAIL rand_resp[%0d]: kind=%0d edge=%0d ready=%b err=%b want %0d %b %b", n,
                   kind, k_hit, cli_ready, cli_err, exp_k, exp_ready, exp_err);
        end
        n_checks++;
        if (cli_data !== m_data || cli_dim_m !== m_dim_m || cli_dim_n !== m_dim_n) begin
          n_errors++;
          $display("FAIL rand_data[%0d]: dims=%0d,%0d data_ok=%b want %0d,%0d 1", n, cli_dim_m,
                   cli_dim_n, cli_data === m_data, m_dim_m, m_dim_n);
        end
      end
      // Winner drops its request; stray store activity lands in RESP and the next IDLE.
      pend &= ~oh;
      cli_req = pend;
      rd_ready = 1'($urandom_range(0, 1));
      err_rd = 1'($urandom_range(0, 1));
      rd_data_flow = rand_mat();
      step();
      n_checks++;
      if (cli_ready !== 3'b000 || cli_err !== 3'b000 || cli_grant !== 3'b000) begin
        n_errors++;
        $display("FAIL rand_release[%0d]: ready=%b err=%b grant=%b want 000 000 000", n,
                 cli_ready, cli_err, cli_grant);
      end
    end
    rd_ready = 1'b0;
    err_rd = 1'b0;
    cli_req = 3'b000;
    repeat (2) step();
    n_checks++;
    if (busy !== 1'b0 || cli_data !== m_data) begin
      n_errors++;
      $display("FAIL rand_final: busy=%b data_ok=%b want 0 1", busy, cli_data === m_data);
    end
  endtask

  initial begin
    for (int c = 0; c < 3; c++) begin
      f_row[c] = '0;
      f_col[c] = '0;
      f_idx[c] = '0;
    end
    model_reset();
    test_reset();
    test_contention();
    test_single();
    test_timeout();
    test_invalid();
    test_err_and_ready();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
